// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg: shared MIPS-I encodings and the decoded control bundle.
//   - opcode, funct, REGIMM rt and COP0 rs field encodings
//   - memtoreg result-select encodings
//   - ctrl_t: packed bundle of every decoded control/exception flag
//   - helpers classifying instructions that occupy or depend on the MDU
package mips_defs_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_COP0   = 6'b010000;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_SLLV    = 6'b000100;
  localparam logic [5:0] F_SRLV    = 6'b000110;
  localparam logic [5:0] F_SRAV    = 6'b000111;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_JALR    = 6'b001001;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_BREAK   = 6'b001101;
  localparam logic [5:0] F_MFHI    = 6'b010000;
  localparam logic [5:0] F_MTHI    = 6'b010001;
  localparam logic [5:0] F_MFLO    = 6'b010010;
  localparam logic [5:0] F_MTLO    = 6'b010011;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_MULTU   = 6'b011001;
  localparam logic [5:0] F_DIV     = 6'b011010;
  localparam logic [5:0] F_DIVU    = 6'b011011;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_ADDU    = 6'b100001;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SUBU    = 6'b100011;
  localparam logic [5:0] F_AND     = 6'b100100;
  localparam logic [5:0] F_OR      = 6'b100101;
  localparam logic [5:0] F_XOR     = 6'b100110;
  localparam logic [5:0] F_NOR     = 6'b100111;
  localparam logic [5:0] F_SLT     = 6'b101010;
  localparam logic [5:0] F_SLTU    = 6'b101011;
  localparam logic [5:0] F_ERET    = 6'b011000;  // under OP_COP0 / RS_CO

  // REGIMM rt selectors (instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // COP0 rs selectors (instr[25:21])
  localparam logic [4:0] RS_MFC0   = 5'b00000;
  localparam logic [4:0] RS_MTC0   = 5'b00100;
  localparam logic [4:0] RS_CO     = 5'b10000;

  // Writeback result select
  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MEM   = 2'b01;
  localparam logic [1:0] M2R_HI    = 2'b10;
  localparam logic [1:0] M2R_LO    = 2'b11;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       gprtohi;
    logic       gprtolo;
    logic       jump;
    logic       jumpr;
    logic       al_regdst;
    logic [1:0] memtoreg;
    logic       ri_exc;
    logic       syscall_exc;
    logic       break_exc;
    logic       eret;
    logic       cp0write;
    logic       cp0read;
  } ctrl_t;

  // mult/multu/div/divu: start an MDU operation
  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && (funct[5:2] == 4'b0110);
  endfunction

  // Everything that must wait for the MDU: mult/div plus HI/LO moves
  function automatic logic is_mdu_dep(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: pure combinational MIPS-I instruction decoder.
//   instr_i : 32-bit instruction word
//   ctrl_o  : decoded control/exception bundle (mips_defs_pkg::ctrl_t)
// Build option: DECODE_CP0_EN enables mtc0/mfc0/eret decode; without it
// every opcode 010000 is reserved and the CP0 flags stay 0.
module decode_comb
  import mips_defs_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_fields;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rt    = instr_i[20:16];

  // Register numbers, shamt and immediates do not affect control.
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

  always_comb begin
    // NOTE: clear the whole bundle first so every path drives every field
    // and no latch is inferred; each case arm then only raises its flags.
    ctrl_o = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: ctrl_o.regwrite = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
            ctrl_o.gprtohi  = 1'b1;
            ctrl_o.gprtolo  = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
            ctrl_o.memtoreg = (funct == F_MFHI) ? M2R_HI : M2R_LO;
          end
          F_MTHI:    ctrl_o.gprtohi     = 1'b1;
          F_MTLO:    ctrl_o.gprtolo     = 1'b1;
          F_JR:      ctrl_o.jumpr       = 1'b1;
          F_JALR: begin
            ctrl_o.jumpr    = 1'b1;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
          end
          F_SYSCALL: ctrl_o.syscall_exc = 1'b1;
          F_BREAK:   ctrl_o.break_exc   = 1'b1;
          default:   ctrl_o.ri_exc      = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: ctrl_o.branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl_o.branch    = 1'b1;
            ctrl_o.regwrite  = 1'b1;
            ctrl_o.al_regdst = 1'b1;
          end
          default: ctrl_o.ri_exc = 1'b1;
        endcase
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.al_regdst = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl_o.branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
        ctrl_o.alusrc   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.memtoreg = M2R_MEM;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.memtoreg = M2R_MEM;
      end
`ifdef DECODE_CP0_EN
      OP_COP0: begin
        case (instr_i[25:21])
          RS_MTC0: ctrl_o.cp0write = 1'b1;
          RS_MFC0: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.cp0read  = 1'b1;
          end
          RS_CO: begin
            if (funct == F_ERET) ctrl_o.eret   = 1'b1;
            else                 ctrl_o.ri_exc = 1'b1;
          end
          default: ctrl_o.ri_exc = 1'b1;
        endcase
      end
`endif
      default: ctrl_o.ri_exc = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: one-stage registered decode with valid/ready handshake and
// a mult/div occupancy counter that stalls HI/LO-dependent instructions.
//   clk, resetn        : clock, asynchronous active-low reset
//   in_valid/in_ready  : upstream handshake; instr, in_pc carried with it
//   flush              : drops the held output and any incoming decode
//   out_valid/out_ready: downstream handshake; out_pc, out_instr registered
//   regwrite..cp0read  : registered decoded control and exception flags
//   mdu_busy           : MDU occupancy counter non-zero
// Parameters: MDU_LAT (mult/div occupancy, >=1), PC_W (pc width).
// Build option: DECODE_CP0_EN enables COP0 decode inside decode_comb.
module decode_ctrl
  import mips_defs_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            regwrite,
  output logic            regdst,
  output logic            alusrc,
  output logic            branch,
  output logic            memwrite,
  output logic            gprtohi,
  output logic            gprtolo,
  output logic            jump,
  output logic            jumpr,
  output logic            al_regdst,
  output logic [1:0]      memtoreg,
  output logic            ri_exc,
  output logic            syscall_exc,
  output logic            break_exc,
  output logic            eret,
  output logic            cp0write,
  output logic            cp0read,
  output logic            mdu_busy
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  ctrl_t            ctrl_d, ctrl_q;
  logic             valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      instr_q;
  logic             mdu_hazard;
  logic             accept;

  decode_comb u_decode (
    .instr_i (instr),
    .ctrl_o  (ctrl_d)
  );

  assign mdu_busy   = (cnt_q != '0);
  assign mdu_hazard = mdu_busy && is_mdu_dep(instr[31:26], instr[5:0]);
  assign in_ready   = !flush && (!out_valid_q || out_ready) && !mdu_hazard;
  assign accept     = in_valid && in_ready;

  // Flush has priority; accept is already blocked by in_ready during flush.
  // The counter runs down freely and is reloaded only when a mult/div is
  // accepted, which the hazard check guarantees happens only at zero.
  always_comb begin
    valid_d = out_valid_q;
    cnt_d   = cnt_q;
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    if (flush) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      if (is_muldiv(instr[31:26], instr[5:0])) cnt_d = CNT_W'(MDU_LAT);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
    end else begin
      out_valid_q <= valid_d;
      cnt_q       <= cnt_d;
      // Payload only moves on accept, so a stalled output stays stable.
      if (accept) begin
        ctrl_q  <= ctrl_d;
        pc_q    <= in_pc;
        instr_q <= instr;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign regwrite    = ctrl_q.regwrite;
  assign regdst      = ctrl_q.regdst;
  assign alusrc      = ctrl_q.alusrc;
  assign branch      = ctrl_q.branch;
  assign memwrite    = ctrl_q.memwrite;
  assign gprtohi     = ctrl_q.gprtohi;
  assign gprtolo     = ctrl_q.gprtolo;
  assign jump        = ctrl_q.jump;
  assign jumpr       = ctrl_q.jumpr;
  assign al_regdst   = ctrl_q.al_regdst;
  assign memtoreg    = ctrl_q.memtoreg;
  assign ri_exc      = ctrl_q.ri_exc;
  assign syscall_exc = ctrl_q.syscall_exc;
  assign break_exc   = ctrl_q.break_exc;
  assign eret        = ctrl_q.eret;
  assign cp0write    = ctrl_q.cp0write;
  assign cp0read     = ctrl_q.cp0read;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: self-checking bench for decode_ctrl (MDU_LAT=4).
// Directed vector table, hand-written handshake/MDU/flush/reset sequences,
// then randomized traffic checked against a behavioural model.
module tb_decode_ctrl;
  import mips_defs_pkg::ctrl_t;

  localparam int MDU_LAT = 4;
  localparam int PC_W    = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic regwrite, regdst, alusrc, branch, memwrite, gprtohi, gprtolo;
  logic jump, jumpr, al_regdst, ri_exc, syscall_exc, break_exc;
  logic eret, cp0write, cp0read, mdu_busy;
  logic [1:0] memtoreg;

  always #5 clk = ~clk;

  decode_ctrl #(.MDU_LAT(MDU_LAT), .PC_W(PC_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .regwrite(regwrite), .regdst(regdst), .alusrc(alusrc), .branch(branch),
    .memwrite(memwrite), .gprtohi(gprtohi), .gprtolo(gprtolo), .jump(jump),
    .jumpr(jumpr), .al_regdst(al_regdst), .memtoreg(memtoreg),
    .ri_exc(ri_exc), .syscall_exc(syscall_exc), .break_exc(break_exc),
    .eret(eret), .cp0write(cp0write), .cp0read(cp0read), .mdu_busy(mdu_busy)
  );

  ctrl_t dut_c;
  always_comb begin
    dut_c = '0;
    dut_c.regwrite = regwrite;   dut_c.regdst = regdst;     dut_c.alusrc = alusrc;
    dut_c.branch = branch;       dut_c.memwrite = memwrite; dut_c.gprtohi = gprtohi;
    dut_c.gprtolo = gprtolo;     dut_c.jump = jump;         dut_c.jumpr = jumpr;
    dut_c.al_regdst = al_regdst; dut_c.memtoreg = memtoreg; dut_c.ri_exc = ri_exc;
    dut_c.syscall_exc = syscall_exc; dut_c.break_exc = break_exc; dut_c.eret = eret;
    dut_c.cp0write = cp0write;   dut_c.cp0read = cp0read;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural decode straight from the instruction-class rules.
  function automatic ctrl_t model(input logic [31:0] ins);
    ctrl_t c;
    int op, fn, rt, rs;
    bit known;
    op = int'(ins[31:26]); fn = int'(ins[5:0]);
    rt = int'(ins[20:16]); rs = int'(ins[25:21]);
    c = '0;
    known = 1'b1;
    if (op == 0) begin
      if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) c.regwrite = 1'b1;
      else if (fn inside {[24:27]}) begin
        c.regwrite = 1'b1; c.regdst = 1'b1; c.gprtohi = 1'b1; c.gprtolo = 1'b1;
      end else if (fn == 16 || fn == 18) begin
        c.regwrite = 1'b1; c.regdst = 1'b1; c.memtoreg = (fn == 16) ? 2'b10 : 2'b11;
      end else if (fn == 17) c.gprtohi = 1'b1;
      else if (fn == 19) c.gprtolo = 1'b1;
      else if (fn == 8) c.jumpr = 1'b1;
      else if (fn == 9) begin c.jumpr = 1'b1; c.regwrite = 1'b1; c.regdst = 1'b1; end
      else if (fn == 12) c.syscall_exc = 1'b1;
      else if (fn == 13) c.break_exc = 1'b1;
      else known = 1'b0;
    end else if (op == 1) begin
      if (rt inside {0, 1}) c.branch = 1'b1;
      else if (rt inside {16, 17}) begin c.branch = 1'b1; c.regwrite = 1'b1; c.al_regdst = 1'b1; end
      else known = 1'b0;
    end else if (op == 2) c.jump = 1'b1;
    else if (op == 3) begin c.jump = 1'b1; c.regwrite = 1'b1; c.al_regdst = 1'b1; end
    else if (op inside {[4:7]}) c.branch = 1'b1;
    else if (op inside {[8:15]}) begin c.regwrite = 1'b1; c.regdst = 1'b1; c.alusrc = 1'b1; end
    else if (op inside {32, 33, 35, 36, 37}) begin
      c.regwrite = 1'b1; c.regdst = 1'b1; c.alusrc = 1'b1; c.memwrite = 1'b1; c.memtoreg = 2'b01;
    end else if (op inside {40, 41, 43}) begin
      c.alusrc = 1'b1; c.memwrite = 1'b1; c.memtoreg = 2'b01;
    end
`ifdef DECODE_CP0_EN
    else if (op == 16) begin
      if (rs == 4) c.cp0write = 1'b1;
      else if (rs == 0) begin c.regwrite = 1'b1; c.cp0read = 1'b1; end
      else if (rs == 16 && fn == 24) c.eret = 1'b1;
      else known = 1'b0;
    end
`endif
    else known = 1'b0;
    if (!known) begin c = '0; c.ri_exc = 1'b1; end
    return c;
  endfunction

  function automatic bit tb_muldiv(input logic [31:0] ins);
    return ins[31:26] == 6'd0 && int'(ins[5:0]) inside {[24:27]};
  endfunction

  function automatic bit tb_dep(input logic [31:0] ins);
    return ins[31:26] == 6'd0 && int'(ins[5:0]) inside {[16:19], [24:27]};
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] i, input ctrl_t e);
    vecs.push_back({i, e});
  endtask

  // Present ins until accepted; stalls = cycles in_ready read low.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    in_valid = 1'b1; instr = ins; in_pc = pc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      stalls++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'(1));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_LW   = 32'h8FA80004;
  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_MFLO = 32'h00001812;
  localparam logic [31:0] I_MULT = 32'h00220018;

  logic [31:0] pool[$];

  function automatic logic [31:0] pick();
    logic [31:0] t;
    if ($urandom_range(0, 15) == 0) return $urandom();
    t = pool[$urandom_range(0, pool.size() - 1)];
    return (t & ~32'h0000FFC0) | ($urandom() & 32'h0000FFC0);
  endfunction

  initial begin
    int st;
    ctrl_t ri;
    bit m_valid;
    logic [31:0] m_instr;
    logic [PC_W-1:0] m_pc;
    longint cyc, busy_until;
    bit exp_ready, busy;

    ri = '0; ri.ri_exc = 1'b1;
    add_vec(I_ADDU,        ctrl_t'{regwrite:1'b1, default:'0});
    add_vec(32'h00021080,  ctrl_t'{regwrite:1'b1, default:'0});
    add_vec(I_LW,          ctrl_t'{regwrite:1'b1, regdst:1'b1, alusrc:1'b1, memwrite:1'b1, memtoreg:2'b01, default:'0});
    add_vec(32'hAFA80004,  ctrl_t'{alusrc:1'b1, memwrite:1'b1, memtoreg:2'b01, default:'0});
    add_vec(32'h24420001,  ctrl_t'{regwrite:1'b1, regdst:1'b1, alusrc:1'b1, default:'0});
    add_vec(32'h3C011234,  ctrl_t'{regwrite:1'b1, regdst:1'b1, alusrc:1'b1, default:'0});
    add_vec(32'h10220003,  ctrl_t'{branch:1'b1, default:'0});
    add_vec(32'h04310002,  ctrl_t'{branch:1'b1, regwrite:1'b1, al_regdst:1'b1, default:'0});
    add_vec(32'h04420000,  ri);
    add_vec(32'h08000010,  ctrl_t'{jump:1'b1, default:'0});
    add_vec(32'h0C000010,  ctrl_t'{jump:1'b1, regwrite:1'b1, al_regdst:1'b1, default:'0});
    add_vec(32'h03E00008,  ctrl_t'{jumpr:1'b1, default:'0});
    add_vec(32'h0040F809,  ctrl_t'{jumpr:1'b1, regwrite:1'b1, regdst:1'b1, default:'0});
    add_vec(32'h00001810,  ctrl_t'{regwrite:1'b1, regdst:1'b1, memtoreg:2'b10, default:'0});
    add_vec(32'h00400011,  ctrl_t'{gprtohi:1'b1, default:'0});
    add_vec(32'h00400013,  ctrl_t'{gprtolo:1'b1, default:'0});
    add_vec(32'hFC000000,  ri);
    add_vec(32'h00000001,  ri);
    add_vec(32'h0000000C,  ctrl_t'{syscall_exc:1'b1, default:'0});
    add_vec(32'h0000000D,  ctrl_t'{break_exc:1'b1, default:'0});
`ifdef DECODE_CP0_EN
    add_vec(32'h42000018,  ctrl_t'{eret:1'b1, default:'0});
    add_vec(32'h40841000,  ctrl_t'{cp0write:1'b1, default:'0});
    add_vec(32'h40041000,  ctrl_t'{regwrite:1'b1, cp0read:1'b1, default:'0});
`else
    add_vec(32'h42000018,  ri);
    add_vec(32'h40841000,  ri);
`endif
    add_vec(I_MULT,        ctrl_t'{regwrite:1'b1, regdst:1'b1, gprtohi:1'b1, gprtolo:1'b1, default:'0});
    foreach (vecs[i]) pool.push_back(vecs[i].instr);
    pool.push_back(I_DIV); pool.push_back(I_MFLO);
    pool.push_back(32'h00220019); pool.push_back(32'h0022001B);

    // Reset state
    resetn = 1'b0; in_valid = 1'b0; instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_ctrl", 64'(dut_c), 64'(0));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    check("rst_mdu_busy", 64'(mdu_busy), 64'(0));
    resetn = 1'b1;

    // Directed decode table
    foreach (vecs[i]) begin
      send(vecs[i].instr, 32'h1000 + 32'(i) * 4, st);
      if (i == 0) check("first_accept_stalls", 64'(st), 64'(0));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("vec%0d_ctrl", i), 64'(dut_c), 64'(vecs[i].exp));
      check($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].instr));
      check($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i) * 4));
    end
    tick();
    check("drain_valid_clear", 64'(out_valid), 64'(0));
    repeat (MDU_LAT + 1) tick();

    // lw held for 3 cycles by out_ready=0
    out_ready = 1'b0;
    send(I_LW, 32'h2000, st);
    in_valid = 1'b1; instr = I_ADDU; in_pc = 32'h2004;
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_memtoreg", 64'(memtoreg), 64'(2'b01));
      check("hold_instr", 64'(out_instr), 64'(I_LW));
      check("hold_pc", 64'(out_pc), 64'(32'h2000));
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    check("release_next_instr", 64'(out_instr), 64'(I_ADDU));
    check("release_next_ctrl", 64'(dut_c), 64'(ctrl_t'{regwrite:1'b1, default:'0}));

    // div then mflo: stalled exactly MDU_LAT cycles
    tick();
    send(I_DIV, 32'h3000, st);
    check("div_busy", 64'(mdu_busy), 64'(1));
    send(I_MFLO, 32'h3004, st);
    check("mflo_stall_cycles", 64'(st), 64'(MDU_LAT));
    check("mflo_memtoreg", 64'(memtoreg), 64'(2'b11));
    check("mflo_instr", 64'(out_instr), 64'(I_MFLO));

    // Independent instruction passes while busy
    send(I_MULT, 32'h3100, st);
    send(I_ADDU, 32'h3104, st);
    check("indep_no_stall", 64'(st), 64'(0));
    check("indep_busy", 64'(mdu_busy), 64'(1));
    repeat (MDU_LAT) tick();

    // Flush while busy with a stalled output and a valid input
    send(I_MULT, 32'h4000, st);
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; instr = I_ADDU;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_mdu_busy", 64'(mdu_busy), 64'(0));

    // Reset pulse mid-stall
    out_ready = 1'b0;
    send(I_MULT, 32'h5000, st);
    in_valid = 1'b1; instr = I_LW;
    #2 resetn = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'(0));
    check("mrst_ctrl", 64'(dut_c), 64'(0));
    check("mrst_out_instr", 64'(out_instr), 64'(0));
    check("mrst_out_pc", 64'(out_pc), 64'(0));
    check("mrst_mdu_busy", 64'(mdu_busy), 64'(0));
    tick();
    resetn = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    send(I_ADDU, 32'h5100, st);
    check("resume_stalls", 64'(st), 64'(0));
    check("resume_instr", 64'(out_instr), 64'(I_ADDU));

    // Randomized traffic against the behavioural model
    flush = 1'b1; tick(); flush = 1'b0;
    m_valid = 1'b0; m_instr = '0; m_pc = '0; cyc = 0; busy_until = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      instr     = pick();
      in_pc     = $urandom();
      busy      = (cyc < busy_until);
      exp_ready = !flush && (!m_valid || out_ready) && !(busy && tb_dep(instr));
      @(negedge clk);
      check("rnd_in_ready", 64'(in_ready), 64'(exp_ready));
      check("rnd_mdu_busy", 64'(mdu_busy), 64'(busy));
      if (flush) begin
        m_valid = 1'b0;
        if (busy_until > cyc + 1) busy_until = cyc + 1;
      end else if (in_valid && exp_ready) begin
        m_valid = 1'b1; m_instr = instr; m_pc = in_pc;
        if (tb_muldiv(instr)) busy_until = cyc + 1 + MDU_LAT;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      tick();
      cyc++;
      check("rnd_out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("rnd_ctrl", 64'(dut_c), 64'(model(m_instr)));
        check("rnd_instr", 64'(out_instr), 64'(m_instr));
        check("rnd_pc", 64'(out_pc), 64'(m_pc));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32: mult/div occupancy in cycles (>=1).
REQ-002 SHALL have parameter PC_W, default 32: width of pc passed alongside instr.
REQ-003 SHALL use ports: clk in 1 clock; resetn in 1 async active-low reset.
REQ-004 SHALL use ports: in_valid in 1; in_ready out 1; instr in 32; in_pc in PC_W.
REQ-005 SHALL use ports: flush in 1, drops held and incoming decode.
REQ-006 SHALL use ports: out_valid out 1; out_ready in 1; out_pc out PC_W; out_instr out 32.
REQ-007 SHALL use ports: regwrite, regdst, alusrc, branch, memwrite, gprtohi, gprtolo, jump, jumpr, al_regdst out 1 each; memtoreg out 2 (00 alu, 01 mem, 10 hi, 11 lo).
REQ-008 SHALL use ports: ri_exc, syscall_exc, break_exc, eret, cp0write, cp0read out 1 each; mdu_busy out 1.
REQ-009 SHALL fix decisions: single clock clk; reset resetn is asynchronous, active-low.

Function
REQ-010 SHALL decode combinationally, then register all control outputs with out_pc/out_instr in one stage; latency 1 cycle from accept to out_valid.
REQ-011 SHALL accept when in_valid && in_ready; in_ready = !flush && (!out_valid || out_ready) && !mdu_hazard.
REQ-012 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-013 SHALL clear out_valid when out_ready without new accept.
REQ-014 SHALL decode: R-type ALU/shift -> regwrite; mult/multu/div/divu -> regwrite, regdst, gprtohi, gprtolo; mfhi/mflo -> regwrite, regdst, memtoreg 10/11; mthi/mtlo -> gprtohi/gprtolo only.
REQ-015 SHALL decode: I-type ALU -> regwrite, regdst, alusrc; loads -> regwrite, regdst, alusrc, memwrite, memtoreg 01; stores -> alusrc, memwrite, memtoreg 01.
REQ-016 SHALL decode: beq/bne/blez/bgtz/bltz/bgez -> branch; bltzal/bgezal -> branch, regwrite, al_regdst; j -> jump; jal -> jump, regwrite, al_regdst; jr -> jumpr; jalr -> jumpr, regwrite, regdst.
REQ-017 SHALL assert ri_exc with all write-enables low for any unlisted opcode, funct, or REGIMM rt.
REQ-018 SHALL assert syscall_exc/break_exc for syscall/break with all write-enables low.
REQ-019 SHALL load an internal counter (width $clog2(MDU_LAT+1)) with MDU_LAT on accept of mult/multu/div/divu; decrement each cycle to 0; mdu_busy = counter != 0.
REQ-020 SHALL define mdu_hazard = mdu_busy && incoming instr is mfhi/mflo/mthi/mtlo/mult/multu/div/divu; other instructions pass freely.
REQ-021 SHALL on flush: clear out_valid and counter next edge; flush wins over simultaneous accept and out_ready.
REQ-022 SHALL at counter==1 deassert mdu_busy next cycle; a hazarded instruction is accepted the cycle mdu_busy reads 0.

Reset
REQ-023 SHALL on resetn low asynchronously clear out_valid, counter, all control/exception outputs, out_pc and out_instr to 0.
REQ-024 SHALL resume acceptance on the first clk edge after resetn deasserts; reset mid-stall discards the held instruction.

Configuration
REQ-025 SHALL, with macro DECODE_CP0_EN defined, decode op 010000: rs 00100 mtc0 -> cp0write; rs 00000 mfc0 -> regwrite, cp0read; rs 10000 funct 011000 eret -> eret; other rs -> ri_exc.
REQ-026 SHALL, without DECODE_CP0_EN, treat all op 010000 as reserved (ri_exc), tie cp0write, cp0read, eret to 0.

Structure
REQ-027 SHALL place opcode/funct/rt/rs encodings, memtoreg encodings, and a packed control-bundle typedef in shared package mips_defs_pkg.
REQ-028 SHALL isolate the pure combinational decoder as sub-module decode_comb; decode_ctrl adds the register stage, handshake, and MDU counter.

Verification
REQ-029 SHALL cover: 0x00221821 (addu) accepted, out_ready=1 -> next cycle out_valid=1, regwrite=1, memtoreg=00, others 0.
REQ-030 SHALL cover: 0x8FA80004 (lw) with out_ready=0 for 3 cycles -> outputs held, in_ready=0, memtoreg=01 throughout.
REQ-031 SHALL cover: MDU_LAT=4, 0x0022001A (div) then 0x00001812 (mflo) -> mflo in_ready=0 for 4 cycles, accepted on 5th, memtoreg=11.
REQ-032 SHALL cover: 0xFC000000 -> ri_exc=1, regwrite=memwrite=0; 0x0000000C -> syscall_exc=1.
REQ-033 SHALL cover: 0x42000018 -> eret=1 with DECODE_CP0_EN, ri_exc=1 without.
REQ-034 SHALL cover: flush with in_valid while mdu_busy -> out_valid=0, mdu_busy=0 next cycle; resetn pulse mid-stall -> all outputs 0 immediately.
